// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mixer_pkg
// Description : Shared types for the IQ mixer LO path: LO sign codes, LO
//               pattern modes and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package mixer_pkg;

  // Sign-select code driven into the mixer for each of I and Q
  typedef enum logic [1:0] {
    LO_ZERO = 2'b00,
    LO_POS  = 2'b01,
    LO_NEG  = 2'b10
  } lo_code_t;

  // LO pattern selected through the configuration handshake
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_DC      = 2'd1,
    MODE_FS4_POS = 2'd2,
    MODE_FS4_NEG = 2'd3
  } lo_mode_t;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } seq_state_t;

  // Last phase of an LO period; the period boundary follows it
  localparam logic [1:0] c_PHASE_LAST = 2'd3;

endpackage : mixer_pkg
`default_nettype wire

// File: rtl/lo_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lo_sequencer_if
// Description : Bundle of the LO sequencer's control, configuration and LO
//               code signals. master = controller side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface lo_sequencer_if #(
  parameter int HOLD_W = 4
) ();

  logic              sample_en;
  logic              run_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_mode;
  logic [HOLD_W-1:0] cfg_hold_m1;
  logic [1:0]        lo_i;
  logic [1:0]        lo_q;
  logic [1:0]        phase;
  logic              busy;
  logic              cfg_applied;

  modport master (
    output sample_en, run_en, cfg_valid, cfg_mode, cfg_hold_m1,
    input  cfg_ready, lo_i, lo_q, phase, busy, cfg_applied
  );

  modport slave (
    input  sample_en, run_en, cfg_valid, cfg_mode, cfg_hold_m1,
    output cfg_ready, lo_i, lo_q, phase, busy, cfg_applied
  );

endinterface : lo_sequencer_if
`default_nettype wire

// File: rtl/lo_code_lut.sv
`default_nettype none
// ============================================================================
// Module      : lo_code_lut
// Description : Combinational map from (LO mode, phase) to the I/Q sign
//               codes. Also used by the mixer bench model.
// Revision    : 1.0 - initial release
// ============================================================================
module lo_code_lut
  import mixer_pkg::*;
(
  input  lo_mode_t   mode,
  input  logic [1:0] phase,
  output lo_code_t   lo_i,
  output lo_code_t   lo_q
);

  // Code table: DC holds I at +1; fs/4 modes rotate a unit phasor, the
  // negative-frequency mode simply mirrors the sign of Q.
  always_comb begin
    lo_i = LO_ZERO;
    lo_q = LO_ZERO;
    case (mode)
      MODE_DC: begin
        lo_i = LO_POS;
      end
      MODE_FS4_POS, MODE_FS4_NEG: begin
        case (phase)
          2'd0: lo_i = LO_POS;
          2'd1: lo_q = (mode == MODE_FS4_POS) ? LO_POS : LO_NEG;
          2'd2: lo_i = LO_NEG;
          default: lo_q = (mode == MODE_FS4_POS) ? LO_NEG : LO_POS;
        endcase
      end
      default: begin
        lo_i = LO_ZERO;
        lo_q = LO_ZERO;
      end
    endcase
  end

endmodule : lo_code_lut
`default_nettype wire

// File: rtl/lo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lo_sequencer
// Description : Per-sample LO code generator (DC, +fs/4, -fs/4) with a
//               programmable per-phase hold. New configurations are staged
//               in a shadow and only take effect on an LO period boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module lo_sequencer
  import mixer_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  lo_sequencer_if.slave   bus
);

  // Registered state
  seq_state_t        r_state;
  lo_mode_t          r_mode;
  logic [HOLD_W-1:0] r_hold_m1;
  lo_mode_t          r_sh_mode;
  logic [HOLD_W-1:0] r_sh_hold_m1;
  logic              r_pending;
  logic [1:0]        r_phase;
  logic [HOLD_W-1:0] r_hold_cnt;
  lo_code_t          r_lo_i;
  lo_code_t          r_lo_q;
  logic              r_cfg_applied;

  // Next-state values
  seq_state_t        w_state_nxt;
  lo_mode_t          w_mode_nxt;
  logic [HOLD_W-1:0] w_hold_m1_nxt;
  lo_mode_t          w_sh_mode_nxt;
  logic [HOLD_W-1:0] w_sh_hold_m1_nxt;
  logic              w_pending_nxt;
  logic [1:0]        w_phase_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_applied_nxt;
  lo_code_t          w_lut_i;
  lo_code_t          w_lut_q;
  lo_code_t          w_lo_i_nxt;
  lo_code_t          w_lo_q_nxt;

  logic              w_cfg_ready;
  logic              w_xfer;
  lo_mode_t          w_cfg_mode;
  lo_mode_t          w_mode_at_boundary;

  assign w_cfg_mode = lo_mode_t'(bus.cfg_mode);

  // Ready is held low during reset; while running only one config can wait.
  assign w_cfg_ready = reset && ((r_state == ST_IDLE) || !r_pending);
  assign w_xfer      = bus.cfg_valid && w_cfg_ready;

  // Mode that will be active after a boundary, used for the stop decision
  assign w_mode_at_boundary = r_pending ? r_sh_mode : r_mode;

  // Next-state / next-config logic for the sequencer FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_mode_nxt       = r_mode;
    w_hold_m1_nxt    = r_hold_m1;
    w_sh_mode_nxt    = r_sh_mode;
    w_sh_hold_m1_nxt = r_sh_hold_m1;
    w_pending_nxt    = r_pending;
    w_phase_nxt      = r_phase;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_applied_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_phase_nxt    = 2'd0;
        w_hold_cnt_nxt = '0;
        if (w_xfer) begin
          w_mode_nxt    = w_cfg_mode;
          w_hold_m1_nxt = bus.cfg_hold_m1;
          w_applied_nxt = 1'b1;
        end else if (r_pending) begin
          w_mode_nxt    = r_sh_mode;
          w_hold_m1_nxt = r_sh_hold_m1;
          w_pending_nxt = 1'b0;
          w_applied_nxt = 1'b1;
        end
        if (bus.run_en && (r_mode != MODE_OFF)) begin
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        // Running or draining: configs go to the shadow only
        if (w_xfer) begin
          w_sh_mode_nxt    = w_cfg_mode;
          w_sh_hold_m1_nxt = bus.cfg_hold_m1;
          w_pending_nxt    = 1'b1;
        end
        w_state_nxt = bus.run_en ? ST_RUN : ST_STOPPING;

        if (bus.sample_en) begin
          if (r_hold_cnt == r_hold_m1) begin
            w_hold_cnt_nxt = '0;
            w_phase_nxt    = r_phase + 2'd1;
            if (r_phase == c_PHASE_LAST) begin
              // Period boundary: swap in a staged config and decide to stop
              if (r_pending) begin
                w_mode_nxt    = r_sh_mode;
                w_hold_m1_nxt = r_sh_hold_m1;
                w_pending_nxt = 1'b0;
                w_applied_nxt = 1'b1;
              end
              if ((r_state == ST_STOPPING) || !bus.run_en ||
                  (w_mode_at_boundary == MODE_OFF)) begin
                w_state_nxt = ST_IDLE;
              end
            end
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // Code lookup on the next mode/phase so the codes come out registered
  lo_code_lut u_lut (
    .mode  (w_mode_nxt),
    .phase (w_phase_nxt),
    .lo_i  (w_lut_i),
    .lo_q  (w_lut_q)
  );

  // The mixer sees zero codes whenever the sequencer is idle
  always_comb begin
    w_lo_i_nxt = LO_ZERO;
    w_lo_q_nxt = LO_ZERO;
    if (w_state_nxt != ST_IDLE) begin
      w_lo_i_nxt = w_lut_i;
      w_lo_q_nxt = w_lut_q;
    end
  end

  // State, config and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_OFF;
      r_hold_m1     <= '0;
      r_sh_mode     <= MODE_OFF;
      r_sh_hold_m1  <= '0;
      r_pending     <= 1'b0;
      r_phase       <= 2'd0;
      r_hold_cnt    <= '0;
      r_lo_i        <= LO_ZERO;
      r_lo_q        <= LO_ZERO;
      r_cfg_applied <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_hold_m1     <= w_hold_m1_nxt;
      r_sh_mode     <= w_sh_mode_nxt;
      r_sh_hold_m1  <= w_sh_hold_m1_nxt;
      r_pending     <= w_pending_nxt;
      r_phase       <= w_phase_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_lo_i        <= w_lo_i_nxt;
      r_lo_q        <= w_lo_q_nxt;
      r_cfg_applied <= w_applied_nxt;
    end
  end

  assign bus.cfg_ready   = w_cfg_ready;
  assign bus.lo_i        = r_lo_i;
  assign bus.lo_q        = r_lo_q;
  assign bus.phase       = r_phase;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.cfg_applied = r_cfg_applied;

endmodule : lo_sequencer
`default_nettype wire
